// File: rtl/seq_playback_ctrl.sv
// seq_playback_ctrl: steps pattern-ROM sequences onto the LEDs.
// Optional pause button enabled by defining SEQ_PAUSE_EN.
module seq_playback_ctrl #(
  parameter int NUM_SEQ  = 8,
  parameter int SEQ_LEN  = 16,
  parameter int DATA_W   = 8,
  parameter int TICK_DIV = 12_500_000,
  localparam int SEQ_W   = $clog2(NUM_SEQ),
  localparam int STEP_W  = $clog2(SEQ_LEN),
  localparam int ADDR_W  = SEQ_W + STEP_W
) (
  input  logic              clk_50,
  input  logic              reset,
  input  logic              pb_seq_up,
  input  logic              pb_seq_dn,
  input  logic [DATA_W-1:0] rom_data,
`ifdef SEQ_PAUSE_EN
  input  logic              pb_pause,
`endif
  output logic [ADDR_W-1:0] rom_addr,
  output logic [SEQ_W-1:0]  seq_num,
  output logic [DATA_W-1:0] leds,
  output logic              step_tick
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] TERM = CNT_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    LATCH = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t              state, state_d;
  logic [STEP_W-1:0]   step, step_d;
  logic [CNT_W-1:0]    tick_cnt, cnt_d;
  logic [SEQ_W-1:0]    seq_d;
  logic [ADDR_W-1:0]   addr_d;
  logic [DATA_W-1:0]   leds_d;
  logic                tick_d;
  logic                up_q, dn_q;
  logic                up_e, dn_e, seq_chg;
  logic                run;

  assign up_e    = pb_seq_up & ~up_q;
  assign dn_e    = pb_seq_dn & ~dn_q;
  assign seq_chg = up_e ^ dn_e;

`ifdef SEQ_PAUSE_EN
  logic pause_q, paused;

  // Pause toggles on each rising edge of the pause button
  always_ff @(posedge clk_50 or negedge reset) begin
    if (!reset) begin
      pause_q <= 1'b0;
      paused  <= 1'b0;
    end else begin
      pause_q <= pb_pause;
      if (pb_pause & ~pause_q)
        paused <= ~paused;
    end
  end

  assign run = ~paused;
`else
  assign run = 1'b1;
`endif

  // Next-state logic; the address is loaded at the event edge so the
  // registered ROM has valid data by the time LATCH samples it
  always_comb begin
    state_d = state;
    seq_d   = seq_num;
    step_d  = step;
    cnt_d   = tick_cnt;
    addr_d  = rom_addr;
    leds_d  = leds;
    tick_d  = 1'b0;
    if (seq_chg) begin
      seq_d   = up_e ? seq_num + SEQ_W'(1)
                     : seq_num - SEQ_W'(1);
      step_d  = '0;
      cnt_d   = '0;
      addr_d  = {seq_d, step_d};
      state_d = FETCH;
    end else begin
      unique case (state)
        FETCH: begin
          addr_d  = {seq_num, step};
          state_d = LATCH;
        end
        LATCH: begin
          leds_d  = rom_data;
          state_d = WAIT;
        end
        WAIT: begin
          if (run) begin
            if (tick_cnt == TERM) begin
              tick_d  = 1'b1;
              step_d  = step + STEP_W'(1);
              cnt_d   = '0;
              addr_d  = {seq_num, step_d};
              state_d = FETCH;
            end else begin
              cnt_d = tick_cnt + CNT_W'(1);
            end
          end
        end
        default: state_d = FETCH;
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk_50 or negedge reset) begin
    if (!reset) begin
      state     <= FETCH;
      seq_num   <= '0;
      step      <= '0;
      tick_cnt  <= '0;
      rom_addr  <= '0;
      leds      <= '0;
      step_tick <= 1'b0;
      up_q      <= 1'b0;
      dn_q      <= 1'b0;
    end else begin
      state     <= state_d;
      seq_num   <= seq_d;
      step      <= step_d;
      tick_cnt  <= cnt_d;
      rom_addr  <= addr_d;
      leds      <= leds_d;
      step_tick <= tick_d;
      up_q      <= pb_seq_up;
      dn_q      <= pb_seq_dn;
    end
  end

endmodule

// File: tb/tb_seq_playback_ctrl.sv
// tb_seq_playback_ctrl: scoreboard bench with a timing-level playback model.
// Define SEQ_PAUSE_EN to exercise the pause button.
module tb_seq_playback_ctrl;

  localparam int NS   = 4;
  localparam int SL   = 4;
  localparam int DW   = 8;
  localparam int TICK = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          up = 1'b0;
  logic          dn = 1'b0;
  logic [DW-1:0] rom_data;
  logic [3:0]    rom_addr;
  logic [1:0]    seq_num;
  logic [DW-1:0] leds;
  logic          step_tick;
`ifdef SEQ_PAUSE_EN
  logic          pause = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  seq_playback_ctrl #(
    .NUM_SEQ(NS), .SEQ_LEN(SL), .DATA_W(DW), .TICK_DIV(TICK)
  ) dut (
    .clk_50(clk),
    .reset(rst_n),
    .pb_seq_up(up),
    .pb_seq_dn(dn),
    .rom_data(rom_data),
`ifdef SEQ_PAUSE_EN
    .pb_pause(pause),
`endif
    .rom_addr(rom_addr),
    .seq_num(seq_num),
    .leds(leds),
    .step_tick(step_tick)
  );

  always #10 clk = ~clk;

  // Registered ROM: word = addr*3
  always_ff @(posedge clk)
    rom_data <= 8'(rom_addr * 3);

  // Reference model state
  int m_seq, m_step, m_cnt, m_busy, m_last;
  bit m_up_q, m_dn_q, m_paused, m_p_q;
  int exp_leds[$];
  int exp_tick[$];

  task automatic model_reset();
    m_seq = 0; m_step = 0; m_cnt = 0;
    m_busy = 2; m_last = 0;
    m_up_q = 0; m_dn_q = 0;
    m_paused = 0; m_p_q = 0;
    exp_leds.delete();
    exp_tick.delete();
  endtask

  task automatic model_step();
    bit ue, de, pe;
    int v;
    ue = up & ~m_up_q;
    de = dn & ~m_dn_q;
    m_up_q = up;
    m_dn_q = dn;
    pe = 0;
`ifdef SEQ_PAUSE_EN
    pe = pause & ~m_p_q;
    m_p_q = pause;
`endif
    if (ue ^ de) begin
      m_seq = ue ? (m_seq + 1) % NS : (m_seq + NS - 1) % NS;
      m_step = 0;
      m_cnt = 0;
      m_busy = 2;
    end else if (m_busy > 0) begin
      m_busy--;
      if (m_busy == 0) begin
        v = ((m_seq * SL + m_step) * 3) % 256;
        if (v != m_last) exp_leds.push_back(v);
        m_last = v;
      end
    end else if (!m_paused) begin
      m_cnt++;
      if (m_cnt == TICK) begin
        m_cnt = 0;
        m_step = (m_step + 1) % SL;
        m_busy = 2;
        exp_tick.push_back(m_seq * SL + m_step);
      end
    end
    if (pe) m_paused = !m_paused;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // Monitor: compare DUT outputs against scoreboard queues
  initial begin
    logic [DW-1:0] prev;
    int e;
    prev = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n) begin
        if (leds != prev) begin
          checks++;
          if (exp_leds.size() == 0) begin
            errors++;
            $display("FAIL leds_unexpected: got %0h required no change", leds);
          end else begin
            e = exp_leds.pop_front();
            if (leds !== 8'(e)) begin
              errors++;
              $display("FAIL leds_value: got %0h required %0h", leds, e);
            end
          end
        end else if (exp_leds.size() > 0) begin
          checks++;
          errors++;
          e = exp_leds.pop_front();
          $display("FAIL leds_missing: got %0h required %0h", leds, e);
        end
        if (step_tick) begin
          checks++;
          if (exp_tick.size() == 0) begin
            errors++;
            $display("FAIL tick_unexpected: got 1 required 0");
          end else begin
            e = exp_tick.pop_front();
            if (rom_addr !== 4'(e) || seq_num !== 2'(e / SL)) begin
              errors++;
              $display("FAIL tick_addr: got %0d/%0d required %0d/%0d",
                       rom_addr, seq_num, e, e / SL);
            end
          end
        end else if (exp_tick.size() > 0) begin
          checks++;
          errors++;
          e = exp_tick.pop_front();
          $display("FAIL tick_missing: got 0 required 1 addr %0d", e);
        end
      end
      prev = leds;
    end
  end

  task automatic check_reset(string tag);
    checks++;
    if (rom_addr !== '0 || seq_num !== '0 || leds !== '0 ||
        step_tick !== 1'b0) begin
      errors++;
      $display("FAIL %s: got addr=%0h seq=%0h leds=%0h tick=%0b required 0",
               tag, rom_addr, seq_num, leds, step_tick);
    end
  endtask

  task automatic rand_run(int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 11) == 0) up = ~up;
      if ($urandom_range(0, 11) == 0) dn = ~dn;
      if ($urandom_range(0, 30) == 0) begin
        up = 1'b0; dn = 1'b0;
        @(negedge clk);
        up = 1'b1; dn = 1'b1;
      end
`ifdef SEQ_PAUSE_EN
      if ($urandom_range(0, 50) == 0) pause = ~pause;
`endif
    end
  endtask

  task automatic idle(int n);
    @(negedge clk);
    up = 1'b0;
    dn = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_reset("reset_state");
    rst_n = 1'b1;
    idle(40);
    @(negedge clk); up = 1'b1;
    idle(12);
    @(negedge clk); dn = 1'b1;
    idle(12);
    @(negedge clk); up = 1'b1; dn = 1'b1;
    idle(12);
    rand_run(1500);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset("mid_reset");
    up = 1'b0; dn = 1'b0;
`ifdef SEQ_PAUSE_EN
    pause = 1'b0;
`endif
    @(negedge clk);
    rst_n = 1'b1;
    idle(20);
`ifdef SEQ_PAUSE_EN
    @(negedge clk); pause = 1'b1;
    idle(25);
    @(negedge clk); up = 1'b1;
    idle(25);
    @(negedge clk); pause = 1'b0;
    @(negedge clk); pause = 1'b1;
    idle(20);
    @(negedge clk); pause = 1'b0;
`endif
    rand_run(1000);
    idle(20);
    checks++;
    if (exp_leds.size() != 0) begin
      errors++;
      $display("FAIL leds_drain: got %0d pending required 0", exp_leds.size());
    end
    checks++;
    if (exp_tick.size() != 0) begin
      errors++;
      $display("FAIL tick_drain: got %0d pending required 0", exp_tick.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
